// File: rtl/aidc_lite_job_scheduler.sv
// aidc_lite_job_scheduler
//
// Holds compression jobs (source address, destination address, byte length)
// written by the APB register block and hands them to the AIDC Lite engine
// one at a time. Each launch is a one-cycle start pulse with the job fields
// held stable until the engine reports done or the scheduler aborts it on
// timeout. Completion, engine errors, zero-length pushes and timeouts are
// recorded in sticky status bits. A level interrupt is raised on every job
// end (done or abort).
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   en_i                allow new launches (an in-flight job always finishes)
//   push_valid_i/_ready_o, push_src_i, push_dst_i, push_len_i
//                       job write from the register block (refused when full)
//   flush_i             drop every queued, not yet launched job
//   eng_start_o         one-cycle launch pulse
//   eng_src_o/_dst_o/_len_o  launched job, stable until done/abort
//   eng_abort_o         one-cycle abort pulse on timeout
//   eng_done_i          engine finished the job, eng_err_i qualifies it
//   busy_o              scheduler FSM not idle
//   q_cnt_o             number of queued jobs
//   done_cnt_o          jobs ended (done or aborted), wraps at 16 bits
//   err_o               sticky {timeout, zero_len, eng_err}
//   irq_en_i, irq_clr_i, irq_o  interrupt enable, clear pulse, level output
module aidc_lite_job_scheduler #(
    parameter int DEPTH       = 4,
    parameter int ADDR_W      = 32,
    parameter int LEN_W       = 16,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en_i,
    input  logic                   push_valid_i,
    output logic                   push_ready_o,
    input  logic [ADDR_W-1:0]      push_src_i,
    input  logic [ADDR_W-1:0]      push_dst_i,
    input  logic [LEN_W-1:0]       push_len_i,
    input  logic                   flush_i,
    output logic                   eng_start_o,
    output logic [ADDR_W-1:0]      eng_src_o,
    output logic [ADDR_W-1:0]      eng_dst_o,
    output logic [LEN_W-1:0]       eng_len_o,
    output logic                   eng_abort_o,
    input  logic                   eng_done_i,
    input  logic                   eng_err_i,
    output logic                   busy_o,
    output logic [$clog2(DEPTH):0] q_cnt_o,
    output logic [15:0]            done_cnt_o,
    output logic [2:0]             err_o,
    input  logic                   irq_en_i,
    input  logic                   irq_clr_i,
    output logic                   irq_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 2 * ADDR_W + LEN_W;

    // The WAIT counter runs 0 .. TIMEOUT_CYC-1; reaching the last value with
    // no done means the job has been waiting TIMEOUT_CYC cycles.
    localparam int                 TO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam bit                 TO_EN   = (TIMEOUT_CYC != 0);
    localparam logic [TO_W-1:0]    TO_LAST = (TIMEOUT_CYC > 0) ? TO_W'(TIMEOUT_CYC - 1) : '0;
    localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    // Job storage: plain array, written on push, read at the head pointer.
    logic [ENT_W-1:0] job_mem [DEPTH];

    state_t            state_q,    state_d;
    logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [TO_W-1:0]   to_cnt_q,   to_cnt_d;
    logic              start_q,    start_d;
    logic              abort_q,    abort_d;
    logic [ADDR_W-1:0] src_q,      src_d;
    logic [ADDR_W-1:0] dst_q,      dst_d;
    logic [LEN_W-1:0]  len_q,      len_d;
    logic [15:0]       done_cnt_q, done_cnt_d;
    logic [2:0]        err_q,      err_d;
    logic              irq_pend_q, irq_pend_d;

    logic              push_fire;
    logic              push_store;
    logic              launch;
    logic [ENT_W-1:0]  head;

    // Full refuses pushes outright, even if a launch frees a slot this cycle.
    assign push_ready_o = (cnt_q != FULL_CNT);
    // A flush in the same cycle wins over the push.
    assign push_fire    = push_valid_i & push_ready_o & ~flush_i;
    // Zero-length jobs are acknowledged but never stored.
    assign push_store   = push_fire & (push_len_i != '0);
    assign launch       = (state_q == ST_IDLE) & en_i & (cnt_q != '0) & ~flush_i;
    assign head         = job_mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push_store) begin
            job_mem[wr_ptr_q] <= {push_src_i, push_dst_i, push_len_i};
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        to_cnt_d   = to_cnt_q;
        start_d    = 1'b0;
        abort_d    = 1'b0;
        src_d      = src_q;
        dst_d      = dst_q;
        len_d      = len_q;
        done_cnt_d = done_cnt_q;
        err_d      = err_q;
        irq_pend_d = irq_pend_q;

        // Clear first so that any set below in the same cycle wins.
        if (irq_clr_i) begin
            err_d      = 3'b000;
            irq_pend_d = 1'b0;
        end

        if (push_fire && (push_len_i == '0)) begin
            err_d[1] = 1'b1;
        end

        // Queue bookkeeping. Flush and launch are exclusive (launch needs !flush).
        if (flush_i) begin
            rd_ptr_d = wr_ptr_q;
            cnt_d    = '0;
        end else begin
            if (push_store) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (launch) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            cnt_d = cnt_q + CNT_W'(push_store) - CNT_W'(launch);
        end

        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    state_d = ST_LAUNCH;
                    start_d = 1'b1;
                    {src_d, dst_d, len_d} = head;
                end
            end
            ST_LAUNCH: begin
                state_d  = ST_WAIT;
                to_cnt_d = '0;
            end
            ST_WAIT: begin
                if (eng_done_i) begin
                    // Done takes priority over a timeout in the same cycle.
                    state_d    = ST_IDLE;
                    done_cnt_d = done_cnt_q + 16'd1;
                    irq_pend_d = 1'b1;
                    if (eng_err_i) begin
                        err_d[0] = 1'b1;
                    end
                end else if (TO_EN && (to_cnt_q == TO_LAST)) begin
                    state_d    = ST_IDLE;
                    abort_d    = 1'b1;
                    err_d[2]   = 1'b1;
                    irq_pend_d = 1'b1;
                    done_cnt_d = done_cnt_q + 16'd1;
                end else if (TO_EN) begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            to_cnt_q   <= '0;
            start_q    <= 1'b0;
            abort_q    <= 1'b0;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            done_cnt_q <= '0;
            err_q      <= '0;
            irq_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            to_cnt_q   <= to_cnt_d;
            start_q    <= start_d;
            abort_q    <= abort_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            len_q      <= len_d;
            done_cnt_q <= done_cnt_d;
            err_q      <= err_d;
            irq_pend_q <= irq_pend_d;
        end
    end

    assign eng_start_o = start_q;
    assign eng_abort_o = abort_q;
    assign eng_src_o   = src_q;
    assign eng_dst_o   = dst_q;
    assign eng_len_o   = len_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign q_cnt_o     = cnt_q;
    assign done_cnt_o  = done_cnt_q;
    assign err_o       = err_q;
    assign irq_o       = irq_pend_q & irq_en_i;

endmodule

// File: tb/tb_aidc_lite_job_scheduler.sv
// Testbench for aidc_lite_job_scheduler (DEPTH=4, TIMEOUT_CYC=16).
// Launched jobs are checked against a queue of expected jobs filled when the
// bench pushes; a table drives the queue-fill sequence; hand-written
// sequences cover launch latency, spacing, timeout, error, flush and reset.
module tb_aidc_lite_job_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_i;
    logic        push_valid_i;
    logic        push_ready_o;
    logic [31:0] push_src_i;
    logic [31:0] push_dst_i;
    logic [15:0] push_len_i;
    logic        flush_i;
    logic        eng_start_o;
    logic [31:0] eng_src_o;
    logic [31:0] eng_dst_o;
    logic [15:0] eng_len_o;
    logic        eng_abort_o;
    logic        eng_done_i;
    logic        eng_err_i;
    logic        busy_o;
    logic [2:0]  q_cnt_o;
    logic [15:0] done_cnt_o;
    logic [2:0]  err_o;
    logic        irq_en_i;
    logic        irq_clr_i;
    logic        irq_o;

    aidc_lite_job_scheduler #(
        .DEPTH(4), .ADDR_W(32), .LEN_W(16), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en_i(en_i),
        .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
        .push_src_i(push_src_i), .push_dst_i(push_dst_i), .push_len_i(push_len_i),
        .flush_i(flush_i), .eng_start_o(eng_start_o),
        .eng_src_o(eng_src_o), .eng_dst_o(eng_dst_o), .eng_len_o(eng_len_o),
        .eng_abort_o(eng_abort_o), .eng_done_i(eng_done_i), .eng_err_i(eng_err_i),
        .busy_o(busy_o), .q_cnt_o(q_cnt_o), .done_cnt_o(done_cnt_o), .err_o(err_o),
        .irq_en_i(irq_en_i), .irq_clr_i(irq_clr_i), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] len;
    } job_t;

    typedef struct {
        logic        valid;
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] len;
        logic        stored;
        logic [2:0]  exp_cnt;
        logic        exp_ready;
        logic [2:0]  exp_err;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_starts = 0;
    job_t exp_q[$];
    int   start_cycles[$];
    vec_t vecs[7];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [79:0] act, logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Scoreboard: every start must match the oldest expected job.
    always @(negedge clk) begin
        if (rst_n && eng_start_o) begin
            job_t e;
            n_starts++;
            start_cycles.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_start: got src 0x%0h expected no launch", eng_src_o);
            end else begin
                e = exp_q.pop_front();
                chk("start_job", {eng_src_o, eng_dst_o, eng_len_o}, e);
                $display("launch cyc %0d src 0x%0h dst 0x%0h len %0d", cyc, eng_src_o, eng_dst_o, eng_len_o);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_job(input logic [31:0] s, input logic [31:0] d,
                            input logic [15:0] l, input bit store);
        push_valid_i = 1'b1;
        push_src_i   = s;
        push_dst_i   = d;
        push_len_i   = l;
        if (store) exp_q.push_back({s, d, l});
        tick();
        push_valid_i = 1'b0;
    endtask

    task automatic wait_start(string name);
        int n = 0;
        tick();
        while (!eng_start_o && n < 20) begin
            tick();
            n++;
        end
        chk(name, eng_start_o, 1);
    endtask

    task automatic pulse_clr();
        irq_clr_i = 1'b1;
        tick();
        irq_clr_i = 1'b0;
    endtask

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        int s0;

        vecs[0] = '{1'b1, 32'h0000_0100, 32'h0000_0200, 16'd16, 1'b1, 3'd1, 1'b1, 3'b000};
        vecs[1] = '{1'b1, 32'h0000_0110, 32'h0000_0210, 16'd32, 1'b1, 3'd2, 1'b1, 3'b000};
        vecs[2] = '{1'b1, 32'h0000_0120, 32'h0000_0220, 16'd48, 1'b1, 3'd3, 1'b1, 3'b000};
        vecs[3] = '{1'b1, 32'h0000_0130, 32'h0000_0230, 16'd64, 1'b1, 3'd4, 1'b0, 3'b000};
        vecs[4] = '{1'b1, 32'h0000_0140, 32'h0000_0240, 16'd80, 1'b0, 3'd4, 1'b0, 3'b000};
        vecs[5] = '{1'b1, 32'h0000_0150, 32'h0000_0250, 16'd0,  1'b0, 3'd4, 1'b0, 3'b000};
        vecs[6] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 16'd0,  1'b0, 3'd4, 1'b0, 3'b000};

        rst_n = 1'b0; en_i = 1'b0; push_valid_i = 1'b0; push_src_i = '0;
        push_dst_i = '0; push_len_i = '0; flush_i = 1'b0; eng_done_i = 1'b0;
        eng_err_i = 1'b0; irq_en_i = 1'b1; irq_clr_i = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_ready", push_ready_o, 1);
        chk("rst_qcnt", q_cnt_o, 0);
        chk("rst_start", eng_start_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done_cnt", done_cnt_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_irq", irq_o, 0);
        rst_n = 1'b1;
        tick();

        // Test 1: single job, launch latency, done, irq
        en_i = 1'b1;
        push_job(32'h1000, 32'h2000, 16'd64, 1'b1);
        chk("t1_qcnt", q_cnt_o, 1);
        chk("t1_no_start_yet", eng_start_o, 0);
        tick();
        chk("t1_start", eng_start_o, 1);
        chk("t1_job", {eng_src_o, eng_dst_o, eng_len_o}, {32'h1000, 32'h2000, 16'd64});
        chk("t1_busy", busy_o, 1);
        tick();
        chk("t1_start_pulse", eng_start_o, 0);
        eng_done_i = 1'b1;
        tick();
        eng_done_i = 1'b0;
        chk("t1_done_cnt", done_cnt_o, 1);
        chk("t1_irq", irq_o, 1);
        chk("t1_idle", busy_o, 0);
        chk("t1_job_held", {eng_src_o, eng_dst_o, eng_len_o}, {32'h1000, 32'h2000, 16'd64});
        pulse_clr();
        chk("t1_irq_clr", irq_o, 0);

        // Test 2: fill queue with en_i=0 from a table, then drain in order
        en_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            push_valid_i = vecs[i].valid;
            push_src_i   = vecs[i].src;
            push_dst_i   = vecs[i].dst;
            push_len_i   = vecs[i].len;
            if (vecs[i].stored) exp_q.push_back({vecs[i].src, vecs[i].dst, vecs[i].len});
            tick();
            $display("vec %0d q_cnt %0d ready %0d err %0d", i, q_cnt_o, push_ready_o, err_o);
            chk($sformatf("t2_vec%0d_qcnt", i), q_cnt_o, vecs[i].exp_cnt);
            chk($sformatf("t2_vec%0d_ready", i), push_ready_o, vecs[i].exp_ready);
            chk($sformatf("t2_vec%0d_err", i), err_o, vecs[i].exp_err);
        end
        push_valid_i = 1'b0;
        base = start_cycles.size();
        en_i = 1'b1;
        for (int j = 0; j < 4; j++) begin
            wait_start($sformatf("t2_start%0d", j));
            tick();
            eng_done_i = 1'b1;
            tick();
            eng_done_i = 1'b0;
        end
        en_i = 1'b0;
        chk("t2_nstarts", start_cycles.size() - base, 4);
        if (start_cycles.size() >= base + 4) begin
            for (int j = 0; j < 3; j++)
                chk($sformatf("t2_spacing%0d", j),
                    start_cycles[base + j + 1] - start_cycles[base + j], 3);
        end
        chk("t2_done_cnt", done_cnt_o, 5);
        chk("t2_empty", q_cnt_o, 0);
        chk("t2_ready", push_ready_o, 1);

        // Test 4: engine error, then irq clear
        en_i = 1'b1;
        push_job(32'h3000, 32'h4000, 16'd100, 1'b1);
        wait_start("t4_start");
        tick();
        eng_done_i = 1'b1;
        eng_err_i  = 1'b1;
        tick();
        eng_done_i = 1'b0;
        eng_err_i  = 1'b0;
        chk("t4_err", err_o, 3'b001);
        chk("t4_done_cnt", done_cnt_o, 6);
        chk("t4_irq", irq_o, 1);
        pulse_clr();
        chk("t4_err_clr", err_o, 0);
        chk("t4_irq_clr", irq_o, 0);

        // irq clear and a new irq in the same cycle: set wins
        push_job(32'h3100, 32'h4100, 16'd12, 1'b1);
        wait_start("t4b_start");
        tick();
        eng_done_i = 1'b1;
        irq_clr_i  = 1'b1;
        tick();
        eng_done_i = 1'b0;
        irq_clr_i  = 1'b0;
        chk("t4b_irq_set_wins", irq_o, 1);
        chk("t4b_done_cnt", done_cnt_o, 7);
        pulse_clr();

        // Test 3: timeout, abort 16 cycles after WAIT entry (17 after start)
        push_job(32'h5000, 32'h6000, 16'd8, 1'b1);
        wait_start("t3_start");
        n = 1;
        tick();
        while (!eng_abort_o && n < 40) begin
            tick();
            n++;
        end
        chk("t3_abort_delay", n, 17);
        chk("t3_err", err_o, 3'b100);
        chk("t3_idle", busy_o, 0);
        chk("t3_irq", irq_o, 1);
        chk("t3_done_cnt", done_cnt_o, 8);
        tick();
        chk("t3_abort_pulse", eng_abort_o, 0);
        eng_done_i = 1'b1;
        tick();
        eng_done_i = 1'b0;
        chk("t3_late_done_ignored", done_cnt_o, 8);
        pulse_clr();

        // Done on the would-be timeout cycle: done wins, no abort
        push_job(32'h5100, 32'h6100, 16'd9, 1'b1);
        wait_start("t3b_start");
        repeat (16) tick();
        eng_done_i = 1'b1;
        tick();
        eng_done_i = 1'b0;
        chk("t3b_no_abort", eng_abort_o, 0);
        chk("t3b_err", err_o, 0);
        chk("t3b_done_cnt", done_cnt_o, 9);
        tick();
        chk("t3b_no_late_abort", eng_abort_o, 0);
        pulse_clr();

        // Test 5: flush while a job is in WAIT, then zero-length push
        en_i = 1'b0;
        push_job(32'h7000, 32'h8000, 16'd1, 1'b1);
        push_job(32'h7100, 32'h8100, 16'd2, 1'b1);
        push_job(32'h7200, 32'h8200, 16'd3, 1'b1);
        en_i = 1'b1;
        wait_start("t5_start");
        chk("t5_qcnt_after_launch", q_cnt_o, 2);
        tick();
        flush_i      = 1'b1;
        push_valid_i = 1'b1;
        push_src_i   = 32'h7300;
        push_dst_i   = 32'h8300;
        push_len_i   = 16'd4;
        tick();
        flush_i      = 1'b0;
        push_valid_i = 1'b0;
        exp_q.delete();
        chk("t5_flush_qcnt", q_cnt_o, 0);
        chk("t5_inflight_busy", busy_o, 1);
        eng_done_i = 1'b1;
        tick();
        eng_done_i = 1'b0;
        chk("t5_done_cnt", done_cnt_o, 10);
        s0 = n_starts;
        repeat (6) tick();
        chk("t5_no_more_starts", n_starts - s0, 0);
        push_job(32'h7400, 32'h8400, 16'd0, 1'b0);
        chk("t5_zero_len_err", err_o, 3'b010);
        chk("t5_zero_len_qcnt", q_cnt_o, 0);
        repeat (4) tick();
        chk("t5_zero_len_no_start", n_starts - s0, 0);

        // Test 6: asynchronous reset in WAIT
        push_job(32'h9000, 32'hA000, 16'd5, 1'b1);
        wait_start("t6_start");
        push_job(32'h9100, 32'hA100, 16'd6, 1'b1);
        chk("t6_busy_before", busy_o, 1);
        chk("t6_qcnt_before", q_cnt_o, 1);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("t6_busy", busy_o, 0);
        chk("t6_qcnt", q_cnt_o, 0);
        chk("t6_ready", push_ready_o, 1);
        chk("t6_done_cnt", done_cnt_o, 0);
        chk("t6_err", err_o, 0);
        chk("t6_irq", irq_o, 0);
        chk("t6_eng_src", eng_src_o, 0);
        tick();
        rst_n = 1'b1;
        s0 = n_starts;
        eng_done_i = 1'b1;
        tick();
        eng_done_i = 1'b0;
        chk("t6_done_ignored", done_cnt_o, 0);
        repeat (4) tick();
        chk("t6_no_start", n_starts - s0, 0);
        chk("t6_idle", busy_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
